// File: rtl/fsm_seq_ctrl_if.sv
// Command/status interface for fsm_seq_ctrl.
//   user_input  : command code, qualified by cmd_valid
//   cmd_valid   : command qualifier
//   out         : current state index (all-ones = FAULT)
//   fault       : high while in FAULT
//   timeout_evt : one-cycle pulse on idle-timeout return to state 0
//   cmd_err     : one-cycle pulse when an undefined command is accepted
// master = command source, slave = the sequencer.
interface fsm_seq_ctrl_if #(
  parameter int STATE_W = 3,
  parameter int CMD_W   = 3
);
  logic [CMD_W-1:0]   user_input;
  logic               cmd_valid;
  logic [STATE_W-1:0] out;
  logic               fault;
  logic               timeout_evt;
  logic               cmd_err;

  modport master (
    output user_input, cmd_valid,
    input  out, fault, timeout_evt, cmd_err
  );

  modport slave (
    input  user_input, cmd_valid,
    output out, fault, timeout_evt, cmd_err
  );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// Parametrised command-driven sequencer.
// Steps through states 0..NUM_STATES-1 on NOP/NEXT/PREV/CLEAR commands,
// enters FAULT (all-ones) on undefined commands or illegal encodings, and
// returns to state 0 after TIMEOUT consecutive idle cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fsm_seq_ctrl_if slave (user_input, cmd_valid in;
//           out, fault, timeout_evt, cmd_err out, all registered)
module fsm_seq_ctrl #(
  parameter int STATE_W    = 3,
  parameter int NUM_STATES = 6,
  parameter int CMD_W      = 3,
  parameter bit WRAP       = 1'b1,
  parameter int TIMEOUT    = 15,
  parameter int TO_W       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fsm_seq_ctrl_if.slave bus
);

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = CMD_W'(0),
    CMD_NEXT  = CMD_W'(1),
    CMD_PREV  = CMD_W'(2),
    CMD_CLEAR = CMD_W'(3)
  } cmd_t;

  localparam logic [STATE_W-1:0] ST_ZERO  = '0;
  localparam logic [STATE_W-1:0] ST_LAST  = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] ST_FAULT = '1;
  localparam logic [TO_W-1:0]    TO_LAST  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  logic [STATE_W-1:0] state_q, state_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic               fault_q, to_q, to_d, err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ZERO;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= (state_d == ST_FAULT);
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    err_d   = 1'b0;

    if (state_q == ST_FAULT) begin
      cnt_d = '0;
      if (bus.cmd_valid && (bus.user_input == CMD_CLEAR)) begin
        state_d = ST_ZERO;
      end
    end else if (state_q > ST_LAST) begin
      // Illegal encoding: always fall into FAULT, silently.
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else if (bus.cmd_valid) begin
      // A valid command beats a timeout expiring on the same cycle.
      cnt_d = '0;
      case (bus.user_input)
        CMD_NOP:   state_d = state_q;
        CMD_NEXT:  state_d = (state_q == ST_LAST) ? (WRAP ? ST_ZERO : ST_LAST)
                                                  : state_q + STATE_W'(1);
        CMD_PREV:  state_d = (state_q == ST_ZERO) ? (WRAP ? ST_LAST : ST_ZERO)
                                                  : state_q - STATE_W'(1);
        CMD_CLEAR: state_d = ST_ZERO;
        default: begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
        end
      endcase
    end else if (state_q == ST_ZERO) begin
      cnt_d = '0;
    end else if (TIMEOUT > 0) begin
      if (cnt_q == TO_LAST) begin
        state_d = ST_ZERO;
        to_d    = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end
  end

  assign bus.out         = state_q;
  assign bus.fault       = fault_q;
  assign bus.timeout_evt = to_q;
  assign bus.cmd_err     = err_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
module tb_fsm_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_seq_ctrl_if #(.STATE_W(3), .CMD_W(3)) if_a ();
  fsm_seq_ctrl_if #(.STATE_W(3), .CMD_W(3)) if_b ();

  fsm_seq_ctrl #(.STATE_W(3), .NUM_STATES(6), .CMD_W(3), .WRAP(1'b1),
                 .TIMEOUT(15), .TO_W(4))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

  fsm_seq_ctrl #(.STATE_W(3), .NUM_STATES(6), .CMD_W(3), .WRAP(1'b0),
                 .TIMEOUT(0), .TO_W(4))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  typedef struct {
    int         dut;
    logic [2:0] out;
    logic       fault;
    logic       to;
    logic       err;
    string      name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NOP = 3'd0, NXT = 3'd1, PRV = 3'd2, CLR = 3'd3;

  task automatic check_now(input string nm, input logic [2:0] ao, input logic af,
                           input logic at, input logic ae, input logic [2:0] eo,
                           input logic ef, input logic et, input logic ee);
    checks++;
    if (ao !== eo || af !== ef || at !== et || ae !== ee) begin
      errors++;
      $display("FAIL %s: got out=%0d fault=%b to=%b err=%b, expected out=%0d fault=%b to=%b err=%b",
               nm, ao, af, at, ae, eo, ef, et, ee);
    end
  endtask

  // Monitor: after each rising edge, compare everything expected for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.dut == 0)
          check_now(e.name, if_a.out, if_a.fault, if_a.timeout_evt, if_a.cmd_err,
                    e.out, e.fault, e.to, e.err);
        else
          check_now(e.name, if_b.out, if_b.fault, if_b.timeout_evt, if_b.cmd_err,
                    e.out, e.fault, e.to, e.err);
      end
    end
  end

  // Drive one cycle of stimulus on the selected DUT (other DUT idle) and
  // queue the response expected after the coming rising edge.
  task automatic step(input int d, input logic v, input logic [2:0] c,
                      input logic [2:0] eo, input logic ef, input logic et,
                      input logic ee, input string nm);
    exp_t e;
    @(negedge clk);
    if_a.cmd_valid  = (d == 0) ? v : 1'b0;
    if_a.user_input = c;
    if_b.cmd_valid  = (d == 1) ? v : 1'b0;
    if_b.user_input = c;
    e.dut = d; e.out = eo; e.fault = ef; e.to = et; e.err = ee; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    if_a.cmd_valid = 1'b0; if_a.user_input = '0;
    if_b.cmd_valid = 1'b0; if_b.user_input = '0;

    // Reset state
    #12;
    check_now("reset_a", if_a.out, if_a.fault, if_a.timeout_evt, if_a.cmd_err, 3'd0, 0, 0, 0);
    check_now("reset_b", if_b.out, if_b.fault, if_b.timeout_evt, if_b.cmd_err, 3'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturating instance (WRAP=0, no timeout)
    step(1, 1, PRV, 3'd0, 0, 0, 0, "b_prev_sat0");
    step(1, 1, NXT, 3'd1, 0, 0, 0, "b_next1");
    step(1, 1, NXT, 3'd2, 0, 0, 0, "b_next2");
    step(1, 1, NXT, 3'd3, 0, 0, 0, "b_next3");
    step(1, 1, NXT, 3'd4, 0, 0, 0, "b_next4");
    step(1, 1, NXT, 3'd5, 0, 0, 0, "b_next5");
    step(1, 1, NXT, 3'd5, 0, 0, 0, "b_next_sat5");
    for (int i = 0; i < 20; i++) step(1, 0, NOP, 3'd5, 0, 0, 0, "b_no_timeout");
    step(1, 1, PRV, 3'd4, 0, 0, 0, "b_prev4");
    step(1, 1, CLR, 3'd0, 0, 0, 0, "b_clear");

    // Wrapping instance: NEXT x6
    step(0, 1, NXT, 3'd1, 0, 0, 0, "a_next1");
    step(0, 1, NXT, 3'd2, 0, 0, 0, "a_next2");
    step(0, 1, NXT, 3'd3, 0, 0, 0, "a_next3");
    step(0, 1, NXT, 3'd4, 0, 0, 0, "a_next4");
    step(0, 1, NXT, 3'd5, 0, 0, 0, "a_next5");
    step(0, 1, NXT, 3'd0, 0, 0, 0, "a_next_wrap0");
    step(0, 1, PRV, 3'd5, 0, 0, 0, "a_prev_wrap5");
    step(0, 1, CLR, 3'd0, 0, 0, 0, "a_clear");

    // Undefined command and FAULT stickiness
    step(0, 1, NXT, 3'd1, 0, 0, 0, "a_f_next1");
    step(0, 1, NXT, 3'd2, 0, 0, 0, "a_f_next2");
    step(0, 1, 3'd5, 3'd7, 1, 0, 1, "a_bad_cmd");
    step(0, 1, NXT, 3'd7, 1, 0, 0, "a_fault_next");
    step(0, 1, PRV, 3'd7, 1, 0, 0, "a_fault_prev");
    step(0, 1, NOP, 3'd7, 1, 0, 0, "a_fault_nop");
    step(0, 1, 3'd6, 3'd7, 1, 0, 0, "a_fault_bad");
    for (int i = 0; i < 16; i++) step(0, 0, NOP, 3'd7, 1, 0, 0, "a_fault_idle");
    step(0, 1, CLR, 3'd0, 0, 0, 0, "a_fault_clear");

    // Idle timeout: 15 idle cycles from state 3
    step(0, 1, NXT, 3'd1, 0, 0, 0, "a_t_next1");
    step(0, 1, NXT, 3'd2, 0, 0, 0, "a_t_next2");
    step(0, 1, NXT, 3'd3, 0, 0, 0, "a_t_next3");
    for (int i = 1; i < 15; i++) step(0, 0, NOP, 3'd3, 0, 0, 0, "a_t_idle");
    step(0, 0, NOP, 3'd0, 0, 1, 0, "a_t_expire");
    step(0, 0, NOP, 3'd0, 0, 0, 0, "a_t_pulse_end");

    // Command on the would-be expiry cycle wins
    step(0, 1, NXT, 3'd1, 0, 0, 0, "a_t2_next1");
    step(0, 1, NXT, 3'd2, 0, 0, 0, "a_t2_next2");
    step(0, 1, NXT, 3'd3, 0, 0, 0, "a_t2_next3");
    for (int i = 1; i < 15; i++) step(0, 0, NOP, 3'd3, 0, 0, 0, "a_t2_idle");
    step(0, 1, NOP, 3'd3, 0, 0, 0, "a_t2_nop_wins");
    step(0, 0, NOP, 3'd3, 0, 0, 0, "a_t2_restart");
    step(0, 1, CLR, 3'd0, 0, 0, 0, "a_t2_clear");

    // Illegal encoding injected into the state register
    step(0, 1, NXT, 3'd1, 0, 0, 0, "a_seu_next1");
    @(negedge clk);
    if_a.cmd_valid = 1'b0;
    force dut_a.state_q = 3'd6;
    #1;
    release dut_a.state_q;
    e.dut = 0; e.out = 3'd7; e.fault = 1'b1; e.to = 1'b0; e.err = 1'b0; e.name = "a_seu_fault";
    sb.push_back(e);
    step(0, 1, CLR, 3'd0, 0, 0, 0, "a_seu_clear");

    // Asynchronous reset mid-sequence
    step(0, 1, NXT, 3'd1, 0, 0, 0, "a_r_next1");
    step(0, 1, NXT, 3'd2, 0, 0, 0, "a_r_next2");
    step(0, 1, NXT, 3'd3, 0, 0, 0, "a_r_next3");
    step(0, 1, NXT, 3'd4, 0, 0, 0, "a_r_next4");
    @(negedge clk);
    if_a.cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_now("a_async_reset", if_a.out, if_a.fault, if_a.timeout_evt, if_a.cmd_err, 3'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, NXT, 3'd1, 0, 0, 0, "a_after_reset");

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
- Parametrised successor to the team's fixed 4-state sequencer FSM.
- Steps through NUM_STATES legal states under command control, exposes the current state index on `out`, and has defensive handling:
  - a dedicated FAULT state,
  - recovery from illegal encodings,
  - rejection of undefined commands,
  - an idle timeout that returns the sequence to state 0.
- Sits between user command decode and the downstream datapath select logic.

Parameters:
- STATE_W, 3, width of state register and `out`.
- NUM_STATES, 6, number of legal sequence states (0..NUM_STATES-1); must satisfy 2 <= NUM_STATES <= 2**STATE_W-1.
- CMD_W, 3, width of `user_input`; must be >= 2.
- WRAP, 1, 1 = NEXT/PREV wrap at the ends; 0 = saturate at the ends.
- TIMEOUT, 15, number of idle cycles before auto-return to state 0; 0 disables the timeout.
- TO_W, 4, idle counter width; must hold TIMEOUT-1.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- user_input  input  CMD_W  command code, sampled only when cmd_valid=1.
- cmd_valid  input  1  command qualifier.
- out  output  STATE_W  current state index; FAULT reads all-ones.
- fault  output  1  high while in FAULT.
- timeout_evt  output  1  one-cycle pulse, coincident with a timeout return to state 0.
- cmd_err  output  1  one-cycle pulse when an undefined command is accepted.

Behaviour:
- Interface:
  - Single clock `clk`.
  - Reset `rst_n` is asynchronous, active-low.
  - All state elements are cleared on negedge rst_n, independent of clk.
- Reset values: state=0, out=0, fault=0, timeout_evt=0, cmd_err=0, idle counter=0.
- Encoding:
  - Legal states are 0..NUM_STATES-1.
  - FAULT = {STATE_W{1'b1}}.
  - Every other encoding is illegal.
- Outputs:
  - All outputs are registered.
  - `out` equals the state register.
  - `fault` = (state == FAULT).
  - Latency: a command sampled at edge N is reflected on `out` after edge N.
- Commands (cmd_valid=1), from a legal state S:
  - 0 NOP: stay in S.
  - 1 NEXT: go to S+1. If S = NUM_STATES-1, go to 0 when WRAP=1, else stay.
  - 2 PREV: go to S-1. If S = 0, go to NUM_STATES-1 when WRAP=1, else stay.
  - 3 CLEAR: go to 0.
  - Any other code: go to FAULT and pulse cmd_err.
- FAULT state:
  - Only CLEAR (cmd_valid=1, code 3) exits, to state 0.
  - Every other input keeps the FSM in FAULT.
  - cmd_err does not pulse while in FAULT.
  - The idle counter is held at 0.
- Illegal encodings (e.g. after SEU):
  - Next state is FAULT unconditionally, whatever the command.
  - Does not pulse cmd_err.
- Idle timeout (TIMEOUT>0):
  - The counter increments on each cycle with cmd_valid=0 while state is in 1..NUM_STATES-1.
  - It clears on any cmd_valid=1 cycle, and whenever state is 0 or FAULT.
  - When the counter is TIMEOUT-1 and the cycle is idle: next state=0, timeout_evt=1 for that one cycle, counter cleared.
  - Net effect: the return to 0 happens after exactly TIMEOUT consecutive idle cycles.
- Simultaneous events:
  - A valid command on the cycle the timeout would expire takes priority; no timeout occurs.
  - Reset dominates everything.
  - Reset asserted mid-sequence or in FAULT returns to state 0 immediately, and all pulses drop.
- No combinational path from user_input to any output.

Test Plan:
- Reset, then NEXT ×6 with NUM_STATES=6, WRAP=1 -> out = 1,2,3,4,5,0; fault=0 throughout.
- WRAP=0: PREV at state 0 -> out stays 0; drive NEXT to reach 5, then NEXT -> out stays 5.
- From state 2, cmd 5 -> next cycle out=7, fault=1, cmd_err pulses one cycle. Then NEXT, PREV, NOP -> stays 7. Then CLEAR -> out=0, fault=0.
- From state 3, hold cmd_valid=0 for 15 cycles -> out=0 after the 15th edge, timeout_evt high exactly one cycle. Repeat, but issue NOP on idle cycle 15 -> no timeout, out=3.
- Force the state register to 6 via bench force/release -> next edge out=7, fault=1, cmd_err=0.
- Assert rst_n low between clock edges while in state 4 -> out=0 immediately, without waiting for a clock edge; fault=0.
